// File: rtl/game_flow_ctrl.sv
// Game sequencer: turns IR keys, frame pulses and saber hits into screen mode,
// countdown, score and winner state for the fencing display path.
module game_flow_ctrl #(
    parameter int          COUNTDOWN_START  = 3,
    parameter int          COUNTDOWN_FRAMES = 60,
    parameter int          FLASH_FRAMES     = 30,
    parameter int          WIN_SCORE        = 5,
    parameter logic [31:0] KEY_START        = 32'h20DF_5BA4,
    parameter logic [31:0] KEY_START_ALT    = 32'h20DF_5AA5,
    parameter logic [31:0] KEY_PAUSE        = 32'h20DF_10EF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] ir_in,
    input  logic        nf_in,
    input  logic        player_hit_in,
    input  logic        opponent_hit_in,
    output logic [2:0]  state_out,
    output logic        display_start_out,
    output logic        game_active_out,
    output logic [3:0]  countdown_out,
    output logic        flash_out,
    output logic [3:0]  player_score_out,
    output logic [3:0]  opponent_score_out,
    output logic [1:0]  winner_out
);
    localparam int CFW = $clog2(COUNTDOWN_FRAMES + 1);
    localparam int FFW = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [2:0] {
        S_START = 3'd0, S_COUNT = 3'd1, S_PLAY = 3'd2,
        S_POINT = 3'd3, S_PAUSE = 3'd4, S_OVER = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     prev_q, prev_d;
    logic [3:0]      cd_q, cd_d;
    logic [CFW-1:0]  cnt_q, cnt_d;
    logic [FFW-1:0]  fcnt_q, fcnt_d;
    logic [3:0]      ps_q, ps_d, os_q, os_d;
    logic [1:0]      win_q, win_d;
    logic            ir_new, start_press, pause_press;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_START;
            prev_q  <= '0;
            cd_q    <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            ps_q    <= '0;
            os_q    <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cd_q    <= cd_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            ps_q    <= ps_d;
            os_q    <= os_d;
            win_q   <= win_d;
        end
    end

    // A held code fires once: only the cycle where ir_in changes counts.
    assign ir_new      = (ir_in != prev_q);
    assign start_press = ir_new && (ir_in == KEY_START || ir_in == KEY_START_ALT);
    assign pause_press = ir_new && (ir_in == KEY_PAUSE);

    always_comb begin
        state_d = state_q;
        prev_d  = ir_in;
        cd_d    = cd_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        ps_d    = ps_q;
        os_d    = os_q;
        win_d   = win_q;
        case (state_q)
            S_START: if (start_press) begin
                state_d = S_COUNT;
                ps_d    = '0;
                os_d    = '0;
                win_d   = '0;
                cd_d    = 4'(COUNTDOWN_START);
                cnt_d   = '0;
            end
            S_COUNT: if (nf_in) begin
                if (cnt_q == CFW'(COUNTDOWN_FRAMES - 1)) begin
                    cnt_d = '0;
                    cd_d  = cd_q - 4'd1;
                    if (cd_q == 4'd1) state_d = S_PLAY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PLAY: begin
                // A hit outranks a coincident pause press, which is dropped.
                if (player_hit_in || opponent_hit_in) begin
                    state_d = S_POINT;
                    fcnt_d  = '0;
                    if (player_hit_in && !opponent_hit_in) ps_d = ps_q + 4'd1;
                    if (opponent_hit_in && !player_hit_in) os_d = os_q + 4'd1;
                end else if (pause_press) begin
                    state_d = S_PAUSE;
                end
            end
            S_POINT: if (nf_in) begin
                if (fcnt_q == FFW'(FLASH_FRAMES - 1)) begin
                    if (ps_q == 4'(WIN_SCORE) || os_q == 4'(WIN_SCORE)) begin
                        state_d = S_OVER;
                        win_d   = (ps_q == 4'(WIN_SCORE)) ? 2'b01 : 2'b10;
                    end else begin
                        state_d = S_COUNT;
                        cd_d    = 4'(COUNTDOWN_START);
                        cnt_d   = '0;
                    end
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_PAUSE: if (pause_press) state_d = S_PLAY;
            S_OVER:  if (start_press) state_d = S_START;
            default: state_d = S_START;
        endcase
    end

    always_comb begin
        state_out          = state_q;
        display_start_out  = (state_q == S_START);
        game_active_out    = (state_q == S_PLAY);
        flash_out          = (state_q == S_POINT);
        countdown_out      = cd_q;
        player_score_out   = ps_q;
        opponent_score_out = os_q;
        winner_out         = win_q;
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed walk through the game flow, then random
// traffic, all checked cycle by cycle against a frame-counting reference model.
module tb_game_flow_ctrl;
    localparam int CS = 3, CF = 2, FF = 2, WIN = 2;
    localparam logic [31:0] KS  = 32'h20DF_5BA4;
    localparam logic [31:0] KSA = 32'h20DF_5AA5;
    localparam logic [31:0] KP  = 32'h20DF_10EF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ir_cur = '0;
    logic        nf = 1'b0, ph = 1'b0, oh = 1'b0;
    logic [2:0]  state_out;
    logic        display_start_out, game_active_out, flash_out;
    logic [3:0]  countdown_out, player_score_out, opponent_score_out;
    logic [1:0]  winner_out;

    int n_vec = 0, n_err = 0;

    // Reference model: state number, scores, winner, and nf pulses seen since entry
    int m_st = 0, m_ps = 0, m_os = 0, m_win = 0, m_nf = 0;
    logic [31:0] m_prev = '0;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .COUNTDOWN_START(CS), .COUNTDOWN_FRAMES(CF), .FLASH_FRAMES(FF), .WIN_SCORE(WIN)
    ) dut (
        .clk_in(clk), .rst_in(rst), .ir_in(ir_cur), .nf_in(nf),
        .player_hit_in(ph), .opponent_hit_in(oh),
        .state_out(state_out), .display_start_out(display_start_out),
        .game_active_out(game_active_out), .countdown_out(countdown_out),
        .flash_out(flash_out), .player_score_out(player_score_out),
        .opponent_score_out(opponent_score_out), .winner_out(winner_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ks, kp;
        ks = (ir_cur != m_prev) && (ir_cur == KS || ir_cur == KSA);
        kp = (ir_cur != m_prev) && (ir_cur == KP);
        if (rst) begin
            m_st = 0; m_ps = 0; m_os = 0; m_win = 0; m_nf = 0; m_prev = '0;
            return;
        end
        case (m_st)
            0: if (ks) begin m_st = 1; m_ps = 0; m_os = 0; m_win = 0; m_nf = 0; end
            1: if (nf) begin m_nf++; if (m_nf == CS * CF) m_st = 2; end
            2: if (ph || oh) begin
                   if (ph && !oh) m_ps++;
                   if (oh && !ph) m_os++;
                   m_st = 3; m_nf = 0;
               end else if (kp) m_st = 4;
            3: if (nf) begin
                   m_nf++;
                   if (m_nf == FF) begin
                       if (m_ps == WIN || m_os == WIN) begin
                           m_st = 5; m_win = (m_ps == WIN) ? 1 : 2;
                       end else begin
                           m_st = 1; m_nf = 0;
                       end
                   end
               end
            4: if (kp) m_st = 2;
            5: if (ks) m_st = 0;
            default: m_st = 0;
        endcase
        m_prev = ir_cur;
    endtask

    task automatic compare_all();
        int exp_cd;
        exp_cd = (m_st == 1) ? CS - m_nf / CF : 0;
        chk("state", 32'(state_out), 32'(m_st));
        chk("disp_start", 32'(display_start_out), 32'(m_st == 0));
        chk("active", 32'(game_active_out), 32'(m_st == 2));
        chk("flash", 32'(flash_out), 32'(m_st == 3));
        chk("countdown", 32'(countdown_out), 32'(exp_cd));
        chk("p_score", 32'(player_score_out), 32'(m_ps));
        chk("o_score", 32'(opponent_score_out), 32'(m_os));
        chk("winner", 32'(winner_out), 32'(m_win));
    endtask

    task automatic step(input logic nf_v, input logic ph_v, input logic oh_v, input logic rst_v);
        nf = nf_v; ph = ph_v; oh = oh_v; rst = rst_v;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // nf pulses spaced five cycles apart
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            idle(4);
        end
    endtask

    initial begin
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_disp", 32'(display_start_out), 32'd1);
        idle(2);

        // Start key held for 10 cycles fires exactly once
        ir_cur = KS;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_state", 32'(state_out), 32'd1);
        chk("start_cd", 32'(countdown_out), 32'd3);
        idle(9);
        chk("start_once", 32'(state_out), 32'd1);

        frames(2);
        chk("cd_after2", 32'(countdown_out), 32'd2);
        frames(2);
        chk("cd_after4", 32'(countdown_out), 32'd1);
        frames(2);
        chk("play_state", 32'(state_out), 32'd2);
        chk("play_cd", 32'(countdown_out), 32'd0);

        // Scoring to a win
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hit1_score", 32'(player_score_out), 32'd1);
        chk("hit1_flash", 32'(flash_out), 32'd1);
        frames(2);
        chk("point_exit", 32'(state_out), 32'd1);
        frames(6);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        frames(2);
        chk("over_state", 32'(state_out), 32'd5);
        chk("over_winner", 32'(winner_out), 32'd1);

        // Back to START with alt key, then a new match
        ir_cur = KSA;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("over_to_start", 32'(state_out), 32'd0);
        chk("held_winner", 32'(winner_out), 32'd1);
        ir_cur = KS;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_winner", 32'(winner_out), 32'd0);
        frames(6);

        // Double hit together with a pause press
        ir_cur = KP;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("dbl_state", 32'(state_out), 32'd3);
        chk("dbl_ps", 32'(player_score_out), 32'd0);
        chk("dbl_os", 32'(opponent_score_out), 32'd0);
        frames(2);
        frames(6);

        // Pause toggle
        ir_cur = '0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        ir_cur = KP;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pause_state", 32'(state_out), 32'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pause_hold", 32'(state_out), 32'd4);
        ir_cur = '0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        ir_cur = KP;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("unpause", 32'(state_out), 32'd2);

        // Reset mid-operation in POINT at 1/1
        step(1'b0, 1'b1, 1'b0, 1'b0);
        frames(2);
        frames(6);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pt_ps", 32'(player_score_out), 32'd1);
        chk("pt_os", 32'(opponent_score_out), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mrst_state", 32'(state_out), 32'd0);
        chk("mrst_ps", 32'(player_score_out), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: ir_cur = KS;
                    1: ir_cur = KSA;
                    2: ir_cur = KP;
                    3: ir_cur = '0;
                    default: ir_cur = $urandom;
                endcase
            end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the fencing display path. It turns IR remote key codes, per-frame pulses and saber-hit events into screen-mode and score state. Its outputs select the start menu, drive the countdown, gate gameplay, flash the point-scored effect and flag the winner. It sits beside the display pipeline and replaces the ad-hoc start-screen latch: `display_start_out` feeds the pixel mux, and the remaining outputs feed the overlay sprites and the game logic.

## Interface
Parameters:
- `COUNTDOWN_START`, default 3: first countdown digit shown; valid range 1–15.
- `COUNTDOWN_FRAMES`, default 60: `nf_in` pulses per countdown digit; must be ≥1.
- `FLASH_FRAMES`, default 30: `nf_in` pulses spent in the point-scored flash; must be ≥1.
- `WIN_SCORE`, default 5: score that ends the match; valid range 1–15.
- `KEY_START`, default 32'h20DF_5BA4: IR code for start.
- `KEY_START_ALT`, default 32'h20DF_5AA5: alternate IR code for start.
- `KEY_PAUSE`, default 32'h20DF_10EF: IR code that toggles pause.

Ports:
- `clk_in` input 1: system clock; the only clock.
- `rst_in` input 1: reset; synchronous, active-high.
- `ir_in` input 32: last decoded IR code, held by the receiver until the next code arrives.
- `nf_in` input 1: new-frame pulse, one cycle wide, once per frame.
- `player_hit_in` input 1: one-cycle pulse when the player's saber lands on the opponent.
- `opponent_hit_in` input 1: one-cycle pulse when the opponent's saber lands on the player.
- `state_out` output 3: current state encoding.
- `display_start_out` output 1: high while in START.
- `game_active_out` output 1: high while in PLAY.
- `countdown_out` output 4: countdown digit; 0 outside COUNTDOWN.
- `flash_out` output 1: high while in POINT.
- `player_score_out` output 4: player score.
- `opponent_score_out` output 4: opponent score.
- `winner_out` output 2: 00 = none, 01 = player, 10 = opponent.

## Operation
- Key detection:
  - A key press is the cycle where `ir_in` differs from its value on the previous cycle and equals a key code.
  - The previous-value register resets to 0.
  - A held code fires exactly once. Pressing the same key twice in a row is not detected until `ir_in` changes.
- State encoding: START=0, COUNTDOWN=1, PLAY=2, POINT=3, PAUSE=4, OVER=5.
- START:
  - Outputs: `display_start_out`=1.
  - A START or START_ALT press moves to COUNTDOWN.
  - On that transition: both scores are cleared, `winner_out` is cleared, `countdown_out` is loaded with COUNTDOWN_START, and the frame counter is set to 0.
- COUNTDOWN:
  - Each `nf_in` increments the frame counter.
  - On an `nf_in` that arrives with the counter at COUNTDOWN_FRAMES−1: the counter goes to 0 and `countdown_out` decrements.
  - If that decrement leaves 0, the block moves to PLAY.
  - Hits and keys are ignored.
- PLAY:
  - Outputs: `game_active_out`=1.
  - `player_hit_in` alone: player score +1, move to POINT.
  - `opponent_hit_in` alone: opponent score +1, move to POINT.
  - Both hits in the same cycle: double hit, no score change, move to POINT.
  - A PAUSE press with no hit moves to PAUSE. If a hit and a PAUSE press coincide, the hit wins and the press is dropped.
- PAUSE:
  - A PAUSE press returns to PLAY.
  - Hits, `nf_in` and start keys are ignored.
- POINT:
  - Outputs: `flash_out`=1. Hits are ignored.
  - The block counts FLASH_FRAMES `nf_in` pulses, from a frame counter reset on entry.
  - If either score equals WIN_SCORE, it moves to OVER. Otherwise it moves to COUNTDOWN, reloading COUNTDOWN_START and clearing the frame counter.
- OVER:
  - `winner_out` is set on entry: 01 if the player score equals WIN_SCORE, else 10.
  - Scores and winner are held.
  - A START or START_ALT press moves to START. Scores and `winner_out` stay held until the next START→COUNTDOWN transition.
- Scores can never exceed WIN_SCORE, because reaching it forces OVER.
- Reset:
  - `rst_in` in any state forces START.
  - Both scores, `countdown_out`, `winner_out` and both counters go to 0.
  - All outputs are at reset values the cycle after reset is sampled.

## Timing
- All outputs are registered and reflect the current state.
- A transition triggered in cycle N is visible in cycle N+1.
- `nf_in` and hits arriving in the same cycle as the transition into a state are not applied to the new state. Counting starts the cycle after entry.
- Countdown length:
  - In COUNTDOWN, the k-th qualifying `nf_in` (k counted from entry) is registered in the same edge as its effect.
  - The transition to PLAY happens on the edge of the (COUNTDOWN_START·COUNTDOWN_FRAMES)-th `nf_in`.
- The POINT exit happens on the edge of the FLASH_FRAMES-th `nf_in`.
- Throughput: one key press per cycle is accepted.
- Reset values:
  - `state_out`=0, `display_start_out`=1.
  - `game_active_out`=0, `flash_out`=0, `countdown_out`=0.
  - Both scores 0, `winner_out`=00.

## Test plan
Parameters for the bench: COUNTDOWN_START=3, COUNTDOWN_FRAMES=2, FLASH_FRAMES=2, WIN_SCORE=2.

- **Reset and start:** reset, then `ir_in` changes to 20DF_5BA4 and is held 10 cycles. Required: `state_out`=1 and `countdown_out`=3 one cycle later, and exactly one transition occurs.
- **Countdown:** 6 `nf_in` pulses spaced 5 cycles apart. Required: `countdown_out` steps 3→2 after pulse 2 and 2→1 after pulse 4; state goes to PLAY with `countdown_out`=0 after pulse 6.
- **Scoring to a win:**
  - In PLAY, a `player_hit_in` pulse. Required: `player_score_out`=1 and `flash_out`=1.
  - After 2 `nf_in`: state COUNTDOWN.
  - Repeat the countdown, then another player hit plus 2 `nf_in`. Required: state OVER, `winner_out`=01.
- **Double hit with pause:** in PLAY, both hits and a PAUSE key change in the same cycle. Required: state POINT, scores unchanged, pause dropped.
- **Pause toggle:** in PLAY, a PAUSE press. Required: state 4; hits and `nf_in` are ignored. Then `ir_in` goes to 0 and back to PAUSE. Required: return to PLAY.
- **Reset mid-operation:** assert `rst_in` in POINT with scores 1/1. Required: next cycle is START with all outputs at reset values.
